// File: rtl/turret_slew_ctrl_if.sv
// Command port for the turret slew controller: firmware-side valid/ready write of a
// per-channel target pulse width.
interface turret_slew_ctrl_if #(
  parameter int CNT_W = 21
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_ch;
  logic [CNT_W-1:0] cmd_target;

  modport master (output cmd_valid, output cmd_ch, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_target, output cmd_ready);
endinterface

// File: rtl/turret_slew_ctrl.sv
// Two-channel servo PWM generator that slews each pulse width toward its commanded
// target by at most STEP cycles per frame and pulses done_int when both arrive.
module turret_slew_ctrl #(
  parameter int PERIOD_CYC = 2000000,
  parameter int MIN_W      = 100000,
  parameter int MAX_W      = 200000,
  parameter int STEP       = 1000,
  parameter int CNT_W      = 21
) (
  input  logic                PCLK,
  input  logic                PRESET,
  turret_slew_ctrl_if.slave   cmd,
  output logic                pwm_out1,
  output logic                pwm_out2,
  output logic                busy,
  output logic                done_int
);

  localparam int SW = CNT_W + 1;
  localparam logic [CNT_W-1:0]        L_LAST   = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0]        L_MIN    = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0]        L_MAX    = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0]        L_CENTER = CNT_W'((MIN_W + MAX_W) / 2);
  localparam logic [CNT_W-1:0]        L_STEP_U = CNT_W'(STEP);
  localparam logic signed [SW-1:0]    L_STEP_S = SW'(STEP);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_MOVING = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_cur_w [0:1];
  logic [CNT_W-1:0] r_tgt_w [0:1];
  logic             r_pwm1;
  logic             r_pwm2;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_cur_nxt [0:1];
  logic [CNT_W-1:0] w_tgt_nxt [0:1];
  logic             w_boundary;
  logic             w_accept;

  function automatic logic [CNT_W-1:0] clamp_w(input logic [CNT_W-1:0] v);
    if (v < L_MIN) begin
      return L_MIN;
    end else if (v > L_MAX) begin
      return L_MAX;
    end else begin
      return v;
    end
  endfunction

  // Widths are clamped to [MIN_W, MAX_W], so the signed difference cannot overflow.
  function automatic logic [CNT_W-1:0] slew_w(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] tgt);
    logic signed [SW-1:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > L_STEP_S) begin
      return cur + L_STEP_U;
    end else if (diff < -L_STEP_S) begin
      return cur - L_STEP_U;
    end else begin
      return tgt;
    end
  endfunction

  assign w_boundary    = (r_frame_cnt == L_LAST);
  assign cmd.cmd_ready = !PRESET && !w_boundary;
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state logic; acceptance and the boundary update are mutually exclusive.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_cur_nxt   = r_cur_w;
    w_tgt_nxt   = r_tgt_w;
    if (w_accept) begin
      w_tgt_nxt[cmd.cmd_ch] = clamp_w(cmd.cmd_target);
      w_state_nxt           = S_MOVING;
    end else if (w_boundary) begin
      case (r_state)
        S_MOVING: begin
          w_cur_nxt[0] = slew_w(r_cur_w[0], r_tgt_w[0]);
          w_cur_nxt[1] = slew_w(r_cur_w[1], r_tgt_w[1]);
          if ((w_cur_nxt[0] == r_tgt_w[0]) && (w_cur_nxt[1] == r_tgt_w[1])) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_MOVING;
          end
        end
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Frame counter and FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_frame_cnt <= '0;
      r_state     <= S_IDLE;
    end else begin
      r_frame_cnt <= w_boundary ? '0 : (r_frame_cnt + CNT_W'(1));
      r_state     <= w_state_nxt;
    end
  end

  // Pulse-width datapath; cur_w only moves on the boundary, so no runt pulses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cur_w[0] <= L_CENTER;
      r_cur_w[1] <= L_CENTER;
      r_tgt_w[0] <= L_CENTER;
      r_tgt_w[1] <= L_CENTER;
    end else begin
      r_cur_w <= w_cur_nxt;
      r_tgt_w <= w_tgt_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pwm1 <= 1'b0;
      r_pwm2 <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_pwm1 <= (r_frame_cnt < r_cur_w[0]);
      r_pwm2 <= (r_frame_cnt < r_cur_w[1]);
      r_busy <= (w_state_nxt == S_MOVING);
      r_done <= w_done_nxt;
    end
  end

  assign pwm_out1 = r_pwm1;
  assign pwm_out2 = r_pwm2;
  assign busy     = r_busy;
  assign done_int = r_done;

endmodule

// File: tb/tb_turret_slew_ctrl.sv
// Directed bench for turret_slew_ctrl with a 100-cycle frame, widths 10..20, step 3.
module tb_turret_slew_ctrl;

  localparam int PERIOD = 100;
  localparam int CW     = 7;

  logic PCLK = 1'b0;
  logic PRESET;
  logic pwm1, pwm2, busy, done_int;
  int   checks = 0;
  int   failures = 0;
  int   tb_fc = 0;

  turret_slew_ctrl_if #(.CNT_W(CW)) cmd_if();

  turret_slew_ctrl #(
    .PERIOD_CYC(100), .MIN_W(10), .MAX_W(20), .STEP(3), .CNT_W(CW)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd(cmd_if),
    .pwm_out1(pwm1), .pwm_out2(pwm2), .busy(busy), .done_int(done_int)
  );

  always #5 PCLK = ~PCLK;

  // Bench-side frame position: at a negedge it equals the frame count of that cycle.
  always @(posedge PCLK) begin
    if (PRESET) tb_fc <= 0;
    else        tb_fc <= (tb_fc == PERIOD - 1) ? 0 : tb_fc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cnt(input int v);
    @(negedge PCLK);
    while (tb_fc != v) @(negedge PCLK);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  // Observe one whole frame (c=0..99), optionally issuing one command at c=inj_c.
  task automatic measure_frame(input int inj_c, input logic inj_ch, input logic [CW-1:0] inj_tgt,
                               output int w1, output int w2, output int dn,
                               output int busy_all, output int busy_end);
    w1 = 0; w2 = 0; dn = 0; busy_all = 1; busy_end = 0;
    wait_cnt(0);
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge PCLK);
      w1 += int'(pwm1);
      w2 += int'(pwm2);
      dn += int'(done_int);
      busy_all &= int'(busy);
      if (i == PERIOD - 1) busy_end = int'(busy);
      if (i == inj_c) begin
        cmd_if.cmd_ch = inj_ch; cmd_if.cmd_target = inj_tgt; cmd_if.cmd_valid = 1'b1;
      end else if (i == inj_c + 1) begin
        cmd_if.cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int w1, w2, dn, ba, be;
    @(negedge PCLK);
    PRESET = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done_int !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_int); end
    checks++; if ({pwm1, pwm2} !== 2'b00) begin failures++; $display("FAIL reset_pwm got=%b exp=00", {pwm1, pwm2}); end
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cmd_if.cmd_ready); end
    PRESET = 1'b0;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", cmd_if.cmd_ready); end
    for (int f = 0; f < 3; f++) begin
      measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
      checks++; if (w1 !== 15) begin failures++; $display("FAIL idle_w1 frame=%0d got=%0d exp=15", f, w1); end
      checks++; if (w2 !== 15) begin failures++; $display("FAIL idle_w2 frame=%0d got=%0d exp=15", f, w2); end
      checks++; if (dn !== 0) begin failures++; $display("FAIL idle_done frame=%0d got=%0d exp=0", f, dn); end
      checks++; if (be !== 0) begin failures++; $display("FAIL idle_busy frame=%0d got=%0d exp=0", f, be); end
    end
  endtask

  task automatic test_slew_up();
    int w1, w2, dn, ba, be;
    int exp_w[3] = '{18, 20, 20};
    int exp_dn[3] = '{0, 1, 0};
    int exp_be[3] = '{1, 0, 0};
    do_reset();
    wait_cnt(50);
    cmd_if.cmd_ch = 1'b0; cmd_if.cmd_target = 7'd20; cmd_if.cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_if.cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy_after_cmd got=%b exp=1", busy); end
    for (int f = 0; f < 3; f++) begin
      measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
      checks++; if (w1 !== exp_w[f]) begin failures++; $display("FAIL up_w1 frame=%0d got=%0d exp=%0d", f, w1, exp_w[f]); end
      checks++; if (w2 !== 15) begin failures++; $display("FAIL up_w2 frame=%0d got=%0d exp=15", f, w2); end
      checks++; if (dn !== exp_dn[f]) begin failures++; $display("FAIL up_done frame=%0d got=%0d exp=%0d", f, dn, exp_dn[f]); end
      checks++; if (be !== exp_be[f]) begin failures++; $display("FAIL up_busy frame=%0d got=%0d exp=%0d", f, be, exp_be[f]); end
    end
  endtask

  task automatic test_clamp();
    int w1, w2, dn, ba, be;
    int exp_w1[3] = '{18, 20, 20};
    int exp_w2[3] = '{12, 10, 10};
    int exp_dn[3] = '{0, 1, 0};
    do_reset();
    wait_cnt(50);
    cmd_if.cmd_ch = 1'b0; cmd_if.cmd_target = 7'd50; cmd_if.cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_if.cmd_ch = 1'b1; cmd_if.cmd_target = 7'd2;
    @(negedge PCLK);
    cmd_if.cmd_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
      checks++; if (w1 !== exp_w1[f]) begin failures++; $display("FAIL clamp_w1 frame=%0d got=%0d exp=%0d", f, w1, exp_w1[f]); end
      checks++; if (w2 !== exp_w2[f]) begin failures++; $display("FAIL clamp_w2 frame=%0d got=%0d exp=%0d", f, w2, exp_w2[f]); end
      checks++; if (dn !== exp_dn[f]) begin failures++; $display("FAIL clamp_done frame=%0d got=%0d exp=%0d", f, dn, exp_dn[f]); end
    end
  endtask

  task automatic test_boundary_hold();
    int w1, w2, dn, ba, be;
    do_reset();
    wait_cnt(99);
    cmd_if.cmd_ch = 1'b1; cmd_if.cmd_target = 7'd12; cmd_if.cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL bnd_ready_low got=%b exp=0", cmd_if.cmd_ready); end
    @(negedge PCLK);
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL bnd_ready_after got=%b exp=1", cmd_if.cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bnd_not_accepted_on_boundary busy=%b exp=0", busy); end
    @(negedge PCLK);
    cmd_if.cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bnd_accepted busy=%b exp=1", busy); end
    measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
    checks++; if (w2 !== 12) begin failures++; $display("FAIL bnd_w2 got=%0d exp=12", w2); end
    checks++; if (w1 !== 15) begin failures++; $display("FAIL bnd_w1 got=%0d exp=15", w1); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL bnd_done got=%0d exp=1", dn); end
  endtask

  task automatic test_retarget();
    int w1, w2, dn, ba, be;
    int exp_w[3] = '{15, 12, 10};
    int exp_dn[3] = '{0, 0, 1};
    int exp_ba[3] = '{1, 1, 0};
    do_reset();
    measure_frame(50, 1'b0, 7'd20, w1, w2, dn, ba, be);
    checks++; if (w1 !== 15) begin failures++; $display("FAIL rt_w1_first got=%0d exp=15", w1); end
    measure_frame(50, 1'b0, 7'd10, w1, w2, dn, ba, be);
    checks++; if (w1 !== 18) begin failures++; $display("FAIL rt_w1_18 got=%0d exp=18", w1); end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rt_done_18 got=%0d exp=0", dn); end
    checks++; if (ba !== 1) begin failures++; $display("FAIL rt_busy_18 got=%0d exp=1", ba); end
    for (int f = 0; f < 3; f++) begin
      measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
      checks++; if (w1 !== exp_w[f]) begin failures++; $display("FAIL rt_w1 frame=%0d got=%0d exp=%0d", f, w1, exp_w[f]); end
      checks++; if (dn !== exp_dn[f]) begin failures++; $display("FAIL rt_done frame=%0d got=%0d exp=%0d", f, dn, exp_dn[f]); end
      checks++; if (ba !== exp_ba[f]) begin failures++; $display("FAIL rt_busy frame=%0d got=%0d exp=%0d", f, ba, exp_ba[f]); end
    end
  endtask

  task automatic test_reset_mid_slew();
    int w1, w2, dn, ba, be;
    do_reset();
    measure_frame(50, 1'b0, 7'd20, w1, w2, dn, ba, be);
    wait_cnt(10);
    checks++; if (pwm1 !== 1'b1) begin failures++; $display("FAIL rs_pwm_before got=%b exp=1", pwm1); end
    PRESET = 1'b1;
    cmd_if.cmd_ch = 1'b1; cmd_if.cmd_target = 7'd20; cmd_if.cmd_valid = 1'b1;
    #1;
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL rs_ready got=%b exp=0", cmd_if.cmd_ready); end
    @(negedge PCLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rs_busy got=%b exp=0", busy); end
    checks++; if ({pwm1, pwm2} !== 2'b00) begin failures++; $display("FAIL rs_pwm got=%b exp=00", {pwm1, pwm2}); end
    checks++; if (done_int !== 1'b0) begin failures++; $display("FAIL rs_done got=%b exp=0", done_int); end
    @(negedge PCLK);
    checks++; if (done_int !== 1'b0) begin failures++; $display("FAIL rs_done2 got=%b exp=0", done_int); end
    PRESET = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      measure_frame(-5, 1'b0, 7'd0, w1, w2, dn, ba, be);
      checks++; if (w1 !== 15) begin failures++; $display("FAIL rs_w1 frame=%0d got=%0d exp=15", f, w1); end
      checks++; if (w2 !== 15) begin failures++; $display("FAIL rs_w2 frame=%0d got=%0d exp=15", f, w2); end
      checks++; if (dn !== 0) begin failures++; $display("FAIL rs_done_after frame=%0d got=%0d exp=0", f, dn); end
      checks++; if (ba !== 0) begin failures++; $display("FAIL rs_busy_after frame=%0d got=%0d exp=0", f, ba); end
    end
  endtask

  initial begin
    PRESET = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch = 1'b0;
    cmd_if.cmd_target = 7'd0;
    test_reset();
    test_slew_up();
    test_clamp();
    test_boundary_hold();
    test_retarget();
    test_reset_mid_slew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
